// File: rtl/disp_pkg.sv
// disp_pkg -- shared definitions for the 4-digit multiplexed hex display.
//
// Contents:
//   NUM_DIGITS  number of multiplexed digits
//   SEG_BLANK   segment pattern with every segment off (active-low)
//   AN_OFF      anode pattern with every digit off (active-low)
//   GLYPH       16-entry hex glyph table, bit order {g,f,e,d,c,b,a}, active-low
//   disp_out_t  bundle of the registered display pins
//   lead_zero() true when digit idx (>=1) and every more-significant digit are zero
//   anode_sel() active-low one-cold anode pattern for a digit index
package disp_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;
  typedef logic [NUM_DIGITS-1:0] anode_t;

  localparam seg_t   SEG_BLANK = 7'h7F;
  localparam anode_t AN_OFF    = 4'hF;

  // Hex glyphs, active-low, {g,f,e,d,c,b,a}. Lower-case b and d keep them
  // distinguishable from 8 and 0.
  localparam seg_t GLYPH [16] = '{
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000, // 7
    7'b0000000, // 8
    7'b0010000, // 9
    7'b0001000, // A
    7'b0000011, // b
    7'b1000110, // C
    7'b0100001, // d
    7'b0000110, // E
    7'b0001110  // F
  };

  typedef struct packed {
    anode_t an_n;
    seg_t   seg_n;
    logic   dp_n;
  } disp_out_t;

  localparam disp_out_t DISP_OFF = '{an_n: AN_OFF, seg_n: SEG_BLANK, dp_n: 1'b1};

  // Digit 0 is never a leading zero so a value of zero still shows "0".
  function automatic logic lead_zero(input logic [15:0] val, input logic [1:0] idx);
    logic lz;
    lz = (idx != 2'd0);
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (d >= int'(idx) && val[4*d +: 4] != 4'h0) begin
        lz = 1'b0;
      end
    end
    return lz;
  endfunction

  function automatic anode_t anode_sel(input logic [1:0] idx);
    return ~(anode_t'(1) << idx);
  endfunction

endpackage

// File: rtl/hex7seg.sv
// hex7seg -- combinational hex nibble to 7-segment glyph decoder.
//
// Ports:
//   nib_i    4-bit hex value
//   seg_n_o  segments {g,f,e,d,c,b,a}, active-low
module hex7seg
  import disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = GLYPH[nib_i];
  end

endmodule

// File: rtl/out_port_display.sv
// out_port_display -- latches a 16-bit CPU output-port value and shows it as
// four hex digits on a multiplexed, active-low 7-segment display.
//
// Parameters:
//   SCAN_DIV   clocks per digit slot (>= 4)
//   BLANK_CYC  dead-time clocks at the start of each slot with all anodes off
//   LZ_BLANK   1 = blank leading zeros on digits 1..3
//
// Ports:
//   clk       system clock, all state on the rising edge
//   rst_n     synchronous active-low reset
//   data_in   value to display
//   data_vld  strobe: data_in is captured on every edge where data_vld=1.
//             There is no ready; the display always accepts, and the last
//             strobed value wins.
//   an_n      digit anodes, active-low, an_n[0] = least-significant digit
//   seg_n     segments {g,f,e,d,c,b,a}, active-low
//   dp_n      decimal point, active-low (always off)
//   shown     currently latched display value
//
// The pins are registered from the current slot index, prescaler and latched
// value, so they lag those by one clock. Because the latched value and the
// slot index both update on the same edge, a strobe that lands on the slot
// tick is seen by the new slot in full -- never half old, half new.
module out_port_display
  import disp_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int LZ_BLANK  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        data_vld,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [15:0] shown
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [15:0]      disp_q, disp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  disp_out_t        out_q, out_d;

  logic       tick;
  logic       dead;
  logic [3:0] cur_nib;
  logic [6:0] cur_glyph;

  // ---------------------------------------------------------------------------
  // Next-state for the latched value, prescaler and digit index
  // ---------------------------------------------------------------------------
  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    disp_d = disp_q;
    cnt_d  = cnt_q + 1'b1;
    idx_d  = idx_q;
    if (data_vld) begin
      disp_d = data_in;
    end
    if (tick) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Glyph for the digit currently being scanned
  // ---------------------------------------------------------------------------
  assign cur_nib = disp_q[{idx_q, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nib_i   (cur_nib),
    .seg_n_o (cur_glyph)
  );

  // Dead time at the start of every slot lets the previous digit's anode
  // turn fully off before the next digit's segments appear (no ghosting).
  assign dead = (32'(cnt_q) < BLANK_CYC);

  always_comb begin
    out_d = DISP_OFF;
    if (!dead) begin
      out_d.an_n = anode_sel(idx_q);
      // A blanked leading zero keeps its anode driven; only the segments go
      // dark, so the brightness duty of the visible digits is unchanged.
      if (LZ_BLANK != 0 && lead_zero(disp_q, idx_q)) begin
        out_d.seg_n = SEG_BLANK;
      end else begin
        out_d.seg_n = cur_glyph;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers; reset wins over a coincident data_vld
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      out_q  <= DISP_OFF;
    end else begin
      disp_q <= disp_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      out_q  <= out_d;
    end
  end

  assign an_n  = out_q.an_n;
  assign seg_n = out_q.seg_n;
  assign dp_n  = out_q.dp_n;
  assign shown = disp_q;

endmodule

// File: tb/tb_out_port_display.sv
module tb_out_port_display;

  localparam int SD = 4;
  localparam int BC = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic        data_vld;

  logic [3:0]  an_n, an_n_nz;
  logic [6:0]  seg_n, seg_n_nz;
  logic        dp_n, dp_n_nz;
  logic [15:0] shown, shown_nz;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: value on display and edges elapsed since reset.
  logic [15:0] m_val = 16'h0;
  int unsigned m_k = 0;
  int unsigned err_before;

  always #5 clk = ~clk;

  out_port_display #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_BLANK(1)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_vld(data_vld),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .shown(shown)
  );

  out_port_display #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_BLANK(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_vld(data_vld),
    .an_n(an_n_nz), .seg_n(seg_n_nz), .dp_n(dp_n_nz), .shown(shown_nz)
  );

  function automatic logic [6:0] ref_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Digit d of value v as it should appear; a digit above 0 whose value and
  // all higher digits are zero is dark when blanking is on.
  function automatic logic [6:0] ref_seg(input logic [15:0] v, input int d, input bit lz);
    int unsigned upper;
    upper = 32'(v) >> (4 * d);
    if (lz && d >= 1 && upper == 0) return 7'h7F;
    return ref_glyph(4'((32'(v) >> (4 * d)) % 16));
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, predict the pins produced by the
  // next rising edge, then compare just after that edge.
  task automatic step(input bit r, input bit v, input logic [15:0] d);
    logic [3:0] e_an;
    logic [6:0] e_seg, e_seg_nz;
    int slot, phase;
    @(negedge clk);
    rst_n = r; data_vld = v; data_in = d;
    @(posedge clk);
    if (!r) begin
      e_an = 4'hF; e_seg = 7'h7F; e_seg_nz = 7'h7F;
      m_val = 16'h0;
      m_k = 0;
    end else begin
      slot  = int'((m_k / SD) % 4);
      phase = int'(m_k % SD);
      if (phase < BC) begin
        e_an = 4'hF; e_seg = 7'h7F; e_seg_nz = 7'h7F;
      end else begin
        e_an     = 4'hF & ~(4'(1) << slot);
        e_seg    = ref_seg(m_val, slot, 1'b1);
        e_seg_nz = ref_seg(m_val, slot, 1'b0);
      end
      if (v) m_val = d;
      m_k++;
    end
    #1;
    check("an_n", 16'(an_n), 16'(e_an));
    check("seg_n", 16'(seg_n), 16'(e_seg));
    check("dp_n", 16'(dp_n), 16'h1);
    check("shown", shown, m_val);
    check("an_n_nolz", 16'(an_n_nz), 16'(e_an));
    check("seg_n_nolz", 16'(seg_n_nz), 16'(e_seg_nz));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0);
  endtask

  initial begin
    rst_n = 1'b0; data_vld = 1'b1; data_in = 16'hFFFF;

    // Reset holds everything dark and ignores the strobe.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'hFFFF);
    check("reset_shown_direct", shown, 16'h0000);
    check("reset_an_direct", 16'(an_n), 16'h000F);

    // Full scan of 1A8F: two complete 16-clock periods.
    step(1'b1, 1'b1, 16'h1A8F);
    run(33);

    // Leading-zero blanking, then the all-zero value.
    step(1'b1, 1'b1, 16'h0005);
    run(20);
    step(1'b1, 1'b1, 16'h0000);
    run(20);
    step(1'b1, 1'b1, 16'h0340);
    run(20);

    // Strobe landing exactly on the slot tick.
    step(1'b1, 1'b1, 16'h1111);
    while ((m_k % SD) != SD - 1) step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'h2222);
    err_before = n_errors;
    run(SD);
    check("coincide_glyph2", 16'(seg_n), 16'(ref_glyph(4'h2)));
    run(12);

    // Reset in the middle of slot 2, then slot 0 dead time first.
    while (((m_k / SD) % 4) != 2 || (m_k % SD) != 2) step(1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'hBEEF);
    check("midreset_shown", shown, 16'h0000);
    step(1'b1, 1'b1, 16'hC0DE);
    check("post_reset_dead", 16'(an_n), 16'h000F);
    step(1'b1, 1'b0, 16'h0);
    check("post_reset_slot0", 16'(an_n), 16'h000E);
    run(18);

    // Randomized traffic with occasional resets and sparse values.
    for (int i = 0; i < 500; i++) begin
      logic [15:0] d;
      d = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 5) == 0), d);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
